// File: rtl/ychip_trace_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ychip_trace_pkg
// Brief    : Shared types and constants for the yChip trace capture block.
// Revision : 1.0
// ============================================================================
package ychip_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } trace_state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] rd2;
        logic [31:0] wb;
        logic [15:0] seq;
    } trace_entry_t;

    localparam int          SEQ_W    = 16;
    localparam logic [31:0] HALT_INS = 32'h0000_0073;

endpackage
`default_nettype wire

// File: rtl/ychip_trace_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : ychip_trace_capture_if
// Brief    : Trace input, control and output stream bundle of the capture block.
// Revision : 1.0
// ============================================================================
interface ychip_trace_capture_if
    import ychip_trace_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              start;
    logic              retire;
    logic [31:0]       ins_in;
    logic [31:0]       rd2_in;
    logic [31:0]       wb_in;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_ins;
    logic [31:0]       out_rd2;
    logic [31:0]       out_wb;
    logic [SEQ_W-1:0]  out_seq;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              busy;
    logic              done;

    modport master (
        output start, retire, ins_in, rd2_in, wb_in, out_ready,
        input  out_valid, out_ins, out_rd2, out_wb, out_seq, count, overflow, busy, done
    );

    modport slave (
        input  start, retire, ins_in, rd2_in, wb_in, out_ready,
        output out_valid, out_ins, out_rd2, out_wb, out_seq, count, overflow, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/ychip_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ychip_trace_fifo
// Brief    : First-word fall-through FIFO; push while full is legal with a pop.
// Revision : 1.0
// ============================================================================
module ychip_trace_fifo
    import ychip_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = $bits(trace_entry_t)
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         pop_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // When full, the slot being written is the one leaving on this same edge.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ychip_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : ychip_trace_capture
// Brief    : Captures yChip retire trace into a FIFO, drained over valid/ready.
//            Optional YCHIP_TRACE_HALT_EN: an ecall retire ends capture early.
// Revision : 1.0
// ============================================================================
module ychip_trace_capture
    import ychip_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LIMIT = 43
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ychip_trace_capture_if.slave  tif
);
    localparam int               CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [SEQ_W-1:0] LIMIT_SEQ = SEQ_W'(LIMIT);

    trace_state_t     r_state;
    logic [SEQ_W-1:0] r_seq_cnt;
    logic             r_overflow;
    logic             r_busy;
    logic             r_done;

    trace_entry_t     w_push_entry;
    trace_entry_t     w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_pop;
    logic             w_capture;
    logic             w_push;
    logic             w_drop;
    logic             w_halt;
    logic [SEQ_W-1:0] w_seq_next;

    always_comb begin
        w_push_entry     = '0;
        w_push_entry.ins = tif.ins_in;
        w_push_entry.rd2 = tif.rd2_in;
        w_push_entry.wb  = tif.wb_in;
        w_push_entry.seq = r_seq_cnt;
    end

    assign w_pop      = !w_empty && tif.out_ready;
    assign w_capture  = (r_state == ST_CAPTURE) && tif.retire;
    assign w_push     = w_capture && (!w_full || w_pop);
    assign w_drop     = w_capture && w_full && !w_pop;
    assign w_seq_next = r_seq_cnt + SEQ_W'(1);

`ifdef YCHIP_TRACE_HALT_EN
    assign w_halt = (tif.ins_in == HALT_INS);
`else
    assign w_halt = 1'b0;
`endif

    ychip_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(trace_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_seq_cnt  <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_seq_cnt  <= '0;
                    r_overflow <= 1'b0;
                    if (tif.start) begin
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (tif.retire) begin
                        // Dropped retires still consume a sequence number.
                        r_seq_cnt <= w_seq_next;
                        if (w_drop) begin
                            r_overflow <= 1'b1;
                        end
                        if ((w_seq_next == LIMIT_SEQ) || w_halt) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tif.out_valid = !w_empty;
    assign tif.out_ins   = w_head.ins;
    assign tif.out_rd2   = w_head.rd2;
    assign tif.out_wb    = w_head.wb;
    assign tif.out_seq   = w_head.seq;
    assign tif.count     = w_count;
    assign tif.overflow  = r_overflow;
    assign tif.busy      = r_busy;
    assign tif.done      = r_done;

endmodule
`default_nettype wire

// File: doc/ychip_trace_capture.md
# ychip_trace_capture

Captures the per-instruction execution trace of `yChip` (`ins`, `rd2`, `wb`) into an on-chip FIFO and presents it to a downstream reader over a valid/ready stream. It is the receiving end of the chip's trace outputs. A run is bounded by a retired-instruction limit, so a bench or debug port can drain results at its own pace instead of sampling `$display`-style on every clock.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of 2, at least 2.
- `LIMIT`, 43: retired instructions per run before capture stops; range 1..65535.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle pulse that begins a run; honoured only in IDLE.
- `retire`  in  1: one cycle per executed instruction; qualifies the three trace inputs.
- `ins_in`  in  32: retired instruction word.
- `rd2_in`  in  32: chip `rd2`.
- `wb_in`  in  32: chip writeback value.
- `out_valid`  out  1: head entry is available.
- `out_ready`  in  1: reader accepts the head entry.
- `out_ins`, `out_rd2`, `out_wb`  out  32 each: head entry fields.
- `out_seq`  out  16: retire index of the head entry, 0-based per run.
- `count`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky; at least one retire was dropped this run.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse on the DRAIN to IDLE transition.

## Operation
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `start` moves to CAPTURE.
  - Clears `seq_cnt` and `overflow`.
  - Does not flush the FIFO.
- CAPTURE:
  - Each `retire` pushes {ins, rd2, wb, seq_cnt}, then `seq_cnt` increments.
  - When `seq_cnt` reaches LIMIT (that retire included), move to DRAIN.
- DRAIN:
  - `retire` is ignored.
  - When the FIFO is empty, move to IDLE and pulse `done`.
- Pop: `out_valid && out_ready` in any state.
- Full FIFO:
  - A retire without a simultaneous pop is dropped; `overflow` sets and `seq_cnt` still increments.
  - A retire with a simultaneous pop is accepted; `count` is unchanged.
- Empty FIFO: `out_valid`=0; `out_ready` has no effect.
- `retire` in IDLE is ignored.
- `start` while `busy` is ignored.
- Pointers wrap modulo DEPTH; `count` ranges 0..DEPTH.
- `seq_cnt` is 16 bits; LIMIT bounds it, so it never wraps within a run.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State=IDLE; pointers, `count` and `seq_cnt` = 0.
  - `out_valid`=0, `out_*`=0, `overflow`=0, `busy`=0, `done`=0.
- Reset mid-run discards all entries; there is no `done` pulse.
- Push latency: a retire at edge N is visible on `out_*` with `out_valid`=1 after edge N if the FIFO was empty.
- Outputs are registered (first-word fall-through); `out_*` are stable while `out_valid && !out_ready`.
- `count` and `overflow` update on the same edge as the push or pop that changes them.
- `busy` rises the edge after `start`.
- `done` is high for exactly one cycle, on the edge the FSM enters IDLE; `busy` falls on that same edge.
- Minimum run with LIMIT=1 and an immediate reader: start, retire, pop, done on successive edges.

## Configuration
- `YCHIP_TRACE_HALT_EN`:
  - Defined: in CAPTURE, a retire with `ins_in` == `HALT_INS` (32'h00000073, ecall) is captured normally and forces DRAIN on that edge, even below LIMIT.
  - Undefined: only LIMIT ends capture; ecall is an ordinary entry.

## Structure
- Package `ychip_trace_pkg`:
  - FSM state enum `trace_state_t`.
  - Packed struct `trace_entry_t` {ins, rd2, wb, seq}, 112 bits.
  - `HALT_INS` constant.
- Sub-module `ychip_trace_fifo`:
  - Parameterised DEPTH, width = `$bits(trace_entry_t)`.
  - push/pop/full/empty/count; simultaneous push+pop when full is legal.
- Top level holds the FSM, `seq_cnt`, overflow logic and `done` generation.

## Test plan
- Basic run:
  - Stimulus: reset, start, LIMIT=43 retires with `ins_in`=i, `wb_in`=2*i; `out_ready`=1.
  - Response: 43 pops in order with seq 0..42 and wb 0..84, then one `done` pulse; `overflow`=0.
- Backpressure overflow:
  - Stimulus: DEPTH=16, `out_ready`=0, 20 retires.
  - Response: `count`=16, `overflow`=1; the reader then drains seq 0..15 only.
- Full simultaneous push/pop:
  - Stimulus: FIFO full, retire with `out_ready`=1 on the same cycle.
  - Response: `count` stays 16, `overflow` stays 0, new entry lands at the tail.
- Reset mid-run:
  - Stimulus: assert `rst_n`=0 after 5 retires, between clock edges.
  - Response: immediate `out_valid`=0, `count`=0, `busy`=0, no `done`.
- Halt (`YCHIP_TRACE_HALT_EN` defined):
  - Stimulus: retire 32'h00000073 as the 3rd instruction.
  - Response: DRAIN after seq 2; 3 entries drained; `done` pulses; later retires are ignored.
- Stray inputs:
  - Stimulus: `start` while `busy`; retire in IDLE.
  - Response: no state change and no push.
